md_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage, fed by the same ID/EX operand bus as the ALU. Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, holding results in internal HI/LO registers. Raises `busy` so hazard logic can stall dependent instructions. Results reach the EX result mux, next to the ALU output, for MFHI/MFLO.

---
 rtl/md_pkg.sv | 43 ++++
 rtl/md_unit.sv | 192 +++++++++++++++++++
 tb/tb_md_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg
// Shared definitions for the multiply/divide unit. The ID-stage decoder and
// the hazard unit import this package too, so the md_op encodings and the
// default latencies live in exactly one place.
//
// Contents:
//   md_op_e             - operation encodings carried on md_op
//   md_state_e          - control states of the md_unit sequencer
//   DEFAULT_MULT_CYCLES - default busy length for MULT/MULTU
//   DEFAULT_DIV_CYCLES  - default busy length for DIV/DIVU
//   CNT_W               - latency counter width, sized by the larger latency
//   isMulDiv()          - true for the four opcodes that occupy the unit

package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110,
      MD_RSVD  = 3'b111
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int DEFAULT_MULT_CYCLES = 5;
   localparam int DEFAULT_DIV_CYCLES  = 10;
   localparam int CNT_W               = 4;

   // Multiplies and divides are the only opcodes that start a busy period;
   // MTHI/MTLO complete in the sampling edge and the rest are no-ops.
   function automatic logic isMulDiv(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) ||
             (op == MD_DIV)  || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit
// Multi-cycle multiply/divide unit in the EX stage. The arithmetic result is
// computed combinationally when the operation is accepted and parked in
// pending registers; a down-counter then models the latency, and hi/lo are
// only written when the counter expires, so they always show committed values.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset_n  in   1  synchronous active-low reset
//   start    in   1  one-cycle strobe, md_op/A/B valid
//   md_op    in   3  operation code (see md_pkg::md_op_e)
//   A        in  32  rs operand: multiplicand / dividend / MTHI-MTLO source
//   B        in  32  rt operand: multiplier / divisor
//   busy     out  1  multiply/divide in flight
//   hi       out 32  HI register
//   lo       out 32  LO register

module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e          state;
   md_state_e          nextState;
   logic [CNT_W-1:0]   count;
   logic               lastCycle;
   logic               accept;

   logic [31:0]        hiReg;
   logic [31:0]        loReg;
   logic [31:0]        pendHi;
   logic [31:0]        pendLo;
   logic               pendWrite;

   logic [31:0]        calcHi;
   logic [31:0]        calcLo;
   logic               calcWrite;
   logic [CNT_W-1:0]   loadCount;

   logic               divOverflow;
   logic [31:0]        sDivisor;
   logic [31:0]        uDivisor;
   logic signed [63:0] sProd;
   logic [63:0]        uProd;
   logic signed [31:0] sQuot;
   logic signed [31:0] sRem;
   logic [31:0]        uQuot;
   logic [31:0]        uRem;

   assign lastCycle = (count == CNT_W'(1));
   assign accept    = start && isMulDiv(md_op);
   assign hi        = hiReg;
   assign lo        = loReg;

   // Datapath arithmetic. The divisor is replaced by 1 whenever the real
   // quotient is either undefined (B=0) or overflows (MIN_INT / -1), so the
   // dividers never see those cases; the results chosen below ignore them.
   assign divOverflow = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
   assign sDivisor    = ((B == 32'd0) || divOverflow) ? 32'd1 : B;
   assign uDivisor    = (B == 32'd0) ? 32'd1 : B;
   assign sProd       = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign uProd       = {32'd0, A} * {32'd0, B};
   assign sQuot       = $signed(A) / $signed(sDivisor);
   assign sRem        = $signed(A) % $signed(sDivisor);
   assign uQuot       = A / uDivisor;
   assign uRem        = A % uDivisor;

   // Select the pending result, its write enable and the latency to load for
   // the incoming opcode. A divide by zero still occupies the full divide
   // latency but leaves hi/lo untouched when it completes.
   always_comb begin
      calcHi    = 32'd0;
      calcLo    = 32'd0;
      calcWrite = 1'b0;
      loadCount = CNT_W'(MULT_CYCLES);
      case (md_op)
         MD_MULT: begin
            {calcHi, calcLo} = sProd;
            calcWrite        = 1'b1;
         end
         MD_MULTU: begin
            {calcHi, calcLo} = uProd;
            calcWrite        = 1'b1;
         end
         MD_DIV: begin
            loadCount = CNT_W'(DIV_CYCLES);
            calcWrite = (B != 32'd0);
            if (divOverflow) begin
               calcLo = 32'h8000_0000;
               calcHi = 32'd0;
            end else begin
               calcLo = sQuot;
               calcHi = sRem;
            end
         end
         MD_DIVU: begin
            loadCount = CNT_W'(DIV_CYCLES);
            calcWrite = (B != 32'd0);
            calcLo    = uQuot;
            calcHi    = uRem;
         end
         default: begin
         end
      endcase
   end

   // Control state register. Reset wins over everything, so an operation in
   // flight is simply dropped back to idle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and busy decode. While busy, start is not looked at at all,
   // which is what makes a start during a busy period harmless.
   always_comb begin
      nextState = state;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               nextState = ST_BUSY;
            end
         end
         ST_BUSY: begin
            busy = 1'b1;
            if (lastCycle) begin
               nextState = ST_IDLE;
            end
         end
         default: begin
            nextState = ST_IDLE;
         end
      endcase
   end

   // Latency counter, pending results and the architectural hi/lo registers.
   // In idle, multiplies/divides capture their result and load the counter,
   // while MTHI/MTLO write straight through. In busy, the counter runs down and
   // the pending pair is committed on the edge where it reaches zero.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count     <= '0;
         hiReg     <= 32'd0;
         loReg     <= 32'd0;
         pendHi    <= 32'd0;
         pendLo    <= 32'd0;
         pendWrite <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  count     <= loadCount;
                  pendHi    <= calcHi;
                  pendLo    <= calcLo;
                  pendWrite <= calcWrite;
               end else if (start && (md_op == MD_MTHI)) begin
                  hiReg <= A;
               end else if (start && (md_op == MD_MTLO)) begin
                  loReg <= A;
               end
            end
            ST_BUSY: begin
               count <= count - CNT_W'(1);
               if (lastCycle && pendWrite) begin
                  hiReg     <= pendHi;
                  loReg     <= pendLo;
                  pendWrite <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
// Self-checking bench for md_unit. Each accepted operation pushes the hi/lo
// pair it should leave behind onto a scoreboard queue; the scenario tasks pop
// that entry once the unit goes idle and compare it with the DUT outputs.

module tb_md_unit;
   import md_pkg::*;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } result_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   result_t     scoreboard[$];
   logic [31:0] modelHi = 32'd0;
   logic [31:0] modelLo = 32'd0;
   int          testsRun = 0;
   int          testsFailed = 0;
   int          protocolViolations = 0;

   md_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .md_op  (md_op),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // Protocol monitor: a start sampled while busy is a violation by the issuer.
   // It is counted here so the dedicated scenario can confirm it was observed.
   always @(posedge clk) begin
      if (reset_n === 1'b1 && start === 1'b1 && busy === 1'b1) begin
         protocolViolations++;
         $display("[TB] protocol: start sampled while busy at %0t", $time);
      end
   end

   // Hard stop in case something outside the bounded waits stalls the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   // Drive one start strobe on the negedge so it is sampled on the next
   // posedge, and optionally push the hi/lo pair the reference model predicts.
   // Returns on the negedge after the sampling edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input bit push);
      result_t exp;
      longint  sA, sB, uA, uB, p, q, r;
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      A     = a;
      B     = b;
      if (push) begin
         sA  = {{32{a[31]}}, a};
         sB  = {{32{b[31]}}, b};
         uA  = {32'd0, a};
         uB  = {32'd0, b};
         exp = '{hi: modelHi, lo: modelLo};
         case (op)
            MD_MULT:  begin p = sA * sB; exp = result_t'(p); end
            MD_MULTU: begin p = uA * uB; exp = result_t'(p); end
            MD_DIV: begin
               if (b != 32'd0) begin
                  q = sA / sB;
                  r = sA % sB;
                  exp.lo = q[31:0];
                  exp.hi = r[31:0];
               end
            end
            MD_DIVU: begin
               if (b != 32'd0) begin
                  q = uA / uB;
                  r = uA % uB;
                  exp.lo = q[31:0];
                  exp.hi = r[31:0];
               end
            end
            MD_MTHI: exp.hi = a;
            MD_MTLO: exp.lo = a;
            default: begin
            end
         endcase
         scoreboard.push_back(exp);
         modelHi = exp.hi;
         modelLo = exp.lo;
      end
      @(negedge clk);
      start = 1'b0;
      md_op = MD_NONE;
      A     = 32'd0;
      B     = 32'd0;
   endtask

   // Count negedges while busy stays high, bounded by a cycle budget.
   task automatic waitIdle(input int budget, output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      start   = 1'b1;
      md_op   = MD_MULT;
      A       = 32'd9;
      B       = 32'd9;
      repeat (3) @(negedge clk);
      start   = 1'b0;
      md_op   = MD_NONE;
      reset_n = 1'b1;
      @(negedge clk);
      testsRun++;
      if (busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_busy: got %b, want 0", busy);
      end
      testsRun++;
      if (hi !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_hi: got %h, want 00000000", hi);
      end
      testsRun++;
      if (lo !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_lo: got %h, want 00000000", lo);
      end
   endtask

   // One multiply or divide: latency, then the scoreboard entry. When
   // holdCheck is set, hi/lo must keep their pre-start values while busy.
   task automatic test_muldiv(input string name, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input int wantCycles, input bit holdCheck);
      result_t exp;
      logic [31:0] oldHi, oldLo;
      int cyc;
      bit held;
      oldHi = hi;
      oldLo = lo;
      held  = 1'b1;
      applyStimulus(op, a, b, 1'b1);
      cyc = 0;
      while (busy === 1'b1 && cyc < 20) begin
         if (hi !== oldHi || lo !== oldLo) held = 1'b0;
         @(negedge clk);
         cyc++;
      end
      testsRun++;
      if (cyc !== wantCycles) begin
         testsFailed++;
         $display("[TB] FAIL %s_busy_cycles: got %0d, want %0d", name, cyc, wantCycles);
      end
      if (holdCheck) begin
         testsRun++;
         if (!held) begin
            testsFailed++;
            $display("[TB] FAIL %s_hold: hi/lo changed while busy, want %h/%h", name, oldHi, oldLo);
         end
      end
      if (scoreboard.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s_scoreboard: got empty queue, want one entry", name);
      end else begin
         exp = scoreboard.pop_front();
         testsRun++;
         if (hi !== exp.hi) begin
            testsFailed++;
            $display("[TB] FAIL %s_hi: got %h, want %h", name, hi, exp.hi);
         end
         testsRun++;
         if (lo !== exp.lo) begin
            testsFailed++;
            $display("[TB] FAIL %s_lo: got %h, want %h", name, lo, exp.lo);
         end
      end
   endtask

   // Spec-level constants cross-check the reference model for the key cases.
   task automatic test_known_values;
      test_muldiv("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b0);
      testsRun++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         testsFailed++;
         $display("[TB] FAIL mult_const: got %h%h, want FFFFFFFFFFFFFFFA", hi, lo);
      end
      test_muldiv("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1);
      testsRun++;
      if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
         testsFailed++;
         $display("[TB] FAIL multu_const: got %h%h, want FFFFFFFE00000001", hi, lo);
      end
      test_muldiv("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b1);
      testsRun++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         testsFailed++;
         $display("[TB] FAIL div_const: got %h/%h, want FFFFFFFF/FFFFFFFD", hi, lo);
      end
      test_muldiv("divu", MD_DIVU, 32'd7, 32'd2, 10, 1'b0);
      testsRun++;
      if ({hi, lo} !== 64'h0000_0001_0000_0003) begin
         testsFailed++;
         $display("[TB] FAIL divu_const: got %h/%h, want 00000001/00000003", hi, lo);
      end
      test_muldiv("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
      testsRun++;
      if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
         testsFailed++;
         $display("[TB] FAIL div_ovf_const: got %h/%h, want 00000000/80000000", hi, lo);
      end
   endtask

   // MTHI/MTLO write one register on the sampling edge without a busy cycle.
   task automatic test_move(input string name, input logic [2:0] op, input logic [31:0] a);
      result_t exp;
      applyStimulus(op, a, 32'd0, 1'b1);
      exp = scoreboard.pop_front();
      testsRun++;
      if (busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL %s_busy: got %b, want 0", name, busy);
      end
      testsRun++;
      if (hi !== exp.hi || lo !== exp.lo) begin
         testsFailed++;
         $display("[TB] FAIL %s_hilo: got %h/%h, want %h/%h", name, hi, lo, exp.hi, exp.lo);
      end
   endtask

   task automatic test_div_zero;
      test_move("mthi", MD_MTHI, 32'h11);
      test_move("mtlo", MD_MTLO, 32'h22);
      test_muldiv("div_zero", MD_DIV, 32'd1234, 32'd0, 10, 1'b1);
      testsRun++;
      if (hi !== 32'h11 || lo !== 32'h22) begin
         testsFailed++;
         $display("[TB] FAIL div_zero_const: got %h/%h, want 00000011/00000022", hi, lo);
      end
   endtask

   // Opcodes 000 and 111 must neither start a busy period nor touch hi/lo.
   task automatic test_noop;
      test_move("op_none", MD_NONE, 32'hDEAD_BEEF);
      test_move("op_rsvd", MD_RSVD, 32'hCAFE_F00D);
   endtask

   task automatic test_reset_midop;
      applyStimulus(MD_MULT, 32'd6, 32'd7, 1'b1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      scoreboard.delete();
      modelHi = 32'd0;
      modelLo = 32'd0;
      testsRun++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_midop: got busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
      repeat (8) @(negedge clk);
      testsRun++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_late_update: got busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
   endtask

   task automatic test_start_while_busy;
      result_t exp;
      int cyc;
      int violationsBefore;
      violationsBefore = protocolViolations;
      applyStimulus(MD_MULT, 32'd6, 32'd7, 1'b1);
      @(negedge clk);
      applyStimulus(MD_DIVU, 32'd100, 32'd3, 1'b0);
      waitIdle(20, cyc);
      testsRun++;
      if (cyc + 3 !== 5) begin
         testsFailed++;
         $display("[TB] FAIL busy_violation_cycles: got %0d, want 5", cyc + 3);
      end
      exp = scoreboard.pop_front();
      testsRun++;
      if (hi !== exp.hi || lo !== exp.lo) begin
         testsFailed++;
         $display("[TB] FAIL busy_violation_result: got %h/%h, want %h/%h", hi, lo, exp.hi, exp.lo);
      end
      testsRun++;
      if (protocolViolations !== violationsBefore + 1) begin
         testsFailed++;
         $display("[TB] FAIL busy_violation_seen: got %0d, want %0d",
                  protocolViolations - violationsBefore, 1);
      end
      repeat (12) @(negedge clk);
      testsRun++;
      if (busy !== 1'b0 || hi !== exp.hi || lo !== exp.lo) begin
         testsFailed++;
         $display("[TB] FAIL busy_violation_late: got busy=%b %h/%h, want 0 %h/%h",
                  busy, hi, lo, exp.hi, exp.lo);
      end
   endtask

   // Random operations issued one after another as soon as busy drops.
   task automatic test_back_to_back;
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom_range(1, 4));
         a  = $urandom();
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
         if (i == 2) b = 32'hFFFF_FFFF;
         test_muldiv("b2b", op, a, b, (op == MD_MULT || op == MD_MULTU) ? 5 : 10, 1'b1);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      md_op   = MD_NONE;
      A       = 32'd0;
      B       = 32'd0;
      test_reset();
      test_known_values();
      test_div_zero();
      test_noop();
      test_reset_midop();
      test_move("mtlo_idle", MD_MTLO, 32'h1234);
      testsRun++;
      if (lo !== 32'h1234) begin
         testsFailed++;
         $display("[TB] FAIL mtlo_const: got %h, want 00001234", lo);
      end
      test_start_while_busy();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
